// File: rtl/fifo_uart_tx_if.sv
// Signal bundle between fifo_uart_tx and its surroundings: FIFO read side plus the UART line
// and status. The master modport is the transmitter's view; the slave modport is the FIFO/system view.
interface fifo_uart_tx_if;
    logic       tx_enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        input  tx_enable, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, tx_done
    );

    modport slave (
        output tx_enable, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an 8-entry FIFO and serialises them LSB first,
// with optional even parity and 1 or 2 stop bits. All outputs come straight from flops.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1085,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);
    localparam int unsigned   CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          parity_q, parity_d;
    logic          tx_q, tx_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned; otherwise synthesis would infer a latch to hold the old value.
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (bus.tx_enable && !bus.fifo_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d  = bus.fifo_data;
                parity_d = ^bus.fifo_data;
                state_d  = START;
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the registered copies line up with it.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of the order of statements in this block.
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            rd_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            rd_en_q  <= rd_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two transmitters (8N1 and 8E2, 4 clocks per bit) fed by queue-based FIFO
// models; expected line waveforms are built from the byte value and the UART framing rules.
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_uart_tx_if ifa();
    fifo_uart_tx_if ifb();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO models: registered data_out on pop, empty flag from occupancy.
    logic [1:0] push_req = '0;
    logic [7:0] push_dat [2];
    logic [7:0] fq0 [$];
    logic [7:0] fq1 [$];
    int cnt0 = 0, cnt1 = 0, rd_cnt0 = 0, rd_cnt1 = 0, bad_pop0 = 0, bad_pop1 = 0;

    always @(posedge clk) begin
        if (ifa.fifo_rd_en) begin
            rd_cnt0 <= rd_cnt0 + 1;
            if (fq0.size() > 0) ifa.fifo_data <= fq0.pop_front();
            else                bad_pop0 <= bad_pop0 + 1;
        end
        if (push_req[0]) fq0.push_back(push_dat[0]);
        cnt0 <= fq0.size();
    end

    always @(posedge clk) begin
        if (ifb.fifo_rd_en) begin
            rd_cnt1 <= rd_cnt1 + 1;
            if (fq1.size() > 0) ifb.fifo_data <= fq1.pop_front();
            else                bad_pop1 <= bad_pop1 + 1;
        end
        if (push_req[1]) fq1.push_back(push_dat[1]);
        cnt1 <= fq1.size();
    end

    assign ifa.fifo_empty = (cnt0 == 0);
    assign ifb.fifo_empty = (cnt1 == 0);

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? ifa.tx : ifb.tx;
    endfunction
    function automatic logic rd_of(input int sel);
        return (sel == 0) ? ifa.fifo_rd_en : ifb.fifo_rd_en;
    endfunction
    function automatic logic busy_of(input int sel);
        return (sel == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel == 0) ? ifa.tx_done : ifb.tx_done;
    endfunction
    function automatic int rdc_of(input int sel);
        return (sel == 0) ? rd_cnt0 : rd_cnt1;
    endfunction
    function automatic int occ_of(input int sel);
        return (sel == 0) ? cnt0 : cnt1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) ifa.tx_enable = v;
        else          ifb.tx_enable = v;
    endtask

    // Called at a negedge; returns one negedge later with the byte visible in the FIFO.
    task automatic push(input int sel, input logic [7:0] b);
        push_req[sel] = 1'b1;
        push_dat[sel] = b;
        @(negedge clk);
        push_req[sel] = 1'b0;
    endtask

    // Line must stay quiet (tx high, no pop, not busy) for n cycles.
    task automatic idle_watch(input string tag, input int sel, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (rd_of(sel) !== 1'b0 || tx_of(sel) !== 1'b1 || busy_of(sel) !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Checks one frame cycle by cycle. lead >= 0: exactly that many tx-high cycles
    // (first one with the FIFO pop) precede the start bit; lead < 0: wait, bounded.
    // drop_at >= 0 deasserts tx_enable at that frame cycle.
    task automatic run_frame(input int sel, input logic [7:0] b, input int lead, input int drop_at);
        logic bits [$];
        int n;
        int cyc;
        int stops;
        stops = sel + 1;
        if (lead >= 0) begin
            for (int i = 0; i < lead; i++) begin
                @(negedge clk);
                check("lead_tx", tx_of(sel), 1'b1);
                check("lead_rd_en", rd_of(sel), (i == 0) ? 1'b1 : 1'b0);
            end
            @(negedge clk);
        end else begin
            n = 0;
            @(negedge clk);
            while (tx_of(sel) !== 1'b0 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        check("start_fall", tx_of(sel), 1'b0);

        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (sel == 1) bits.push_back(^b);
        for (int s = 0; s < stops; s++) bits.push_back(1'b1);

        cyc = 0;
        foreach (bits[k]) begin
            for (int j = 0; j < CPB; j++) begin
                if (k != 0 || j != 0) @(negedge clk);
                if (cyc == drop_at) set_en(sel, 1'b0);
                check("tx_bit", tx_of(sel), bits[k]);
                if (j == 0) begin
                    check("busy_in_frame", busy_of(sel), 1'b1);
                    check("done_in_frame", done_of(sel), 1'b0);
                    check("rd_en_in_frame", rd_of(sel), 1'b0);
                end
                cyc++;
            end
        end
        @(negedge clk);
        check("tx_done_pulse", done_of(sel), 1'b1);
        check("busy_after", busy_of(sel), 1'b0);
        check("tx_idle_after", tx_of(sel), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] expq [$];
        logic [7:0] r;
        logic [7:0] b81;
        int rd0;
        int bad;
        int n;

        rst = 1'b1;
        ifa.tx_enable = 1'b0;
        ifb.tx_enable = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_tx", tx_of(s), 1'b1);
            check("reset_rd_en", rd_of(s), 1'b0);
            check("reset_busy", busy_of(s), 1'b0);
            check("reset_done", done_of(s), 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0xA5 with tx_enable already high.
        rd0 = rdc_of(0);
        set_en(0, 1'b1);
        push(0, 8'hA5);
        run_frame(0, 8'hA5, -1, -1);
        check("single_rd_pulses", rdc_of(0) - rd0, 1);
        check("single_fifo_empty", occ_of(0), 0);
        @(negedge clk);
        check("single_busy_low", busy_of(0), 1'b0);
        check("single_done_low", done_of(0), 1'b0);

        // Back-to-back 0x00, 0xFF, 0x3C: three idle cycles between frames.
        set_en(0, 1'b0);
        rd0 = rdc_of(0);
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h3C);
        set_en(0, 1'b1);
        run_frame(0, 8'h00, 2, -1);
        run_frame(0, 8'hFF, 2, -1);
        run_frame(0, 8'h3C, 2, -1);
        check("b2b_rd_pulses", rdc_of(0) - rd0, 3);
        check("b2b_fifo_empty", occ_of(0), 0);

        // Even parity with two stop bits: 0x07 -> parity 1, 0x03 -> parity 0.
        push(1, 8'h07);
        push(1, 8'h03);
        set_en(1, 1'b1);
        run_frame(1, 8'h07, 2, -1);
        run_frame(1, 8'h03, 2, -1);
        check("par_fifo_empty", occ_of(1), 0);

        // Gating by tx_enable, including deassertion mid-data.
        set_en(0, 1'b0);
        push(0, 8'h55);
        push(0, 8'h11);
        idle_watch("gate_hold", 0, 20);
        rd0 = rdc_of(0);
        set_en(0, 1'b1);
        run_frame(0, 8'h55, 2, 18);
        idle_watch("gate_no_refetch", 0, 10);
        check("gate_rd_pulses", rdc_of(0) - rd0, 1);
        set_en(0, 1'b1);
        run_frame(0, 8'h11, 2, -1);

        // Empty FIFO with tx_enable high.
        idle_watch("empty_quiet", 0, 50);
        check("empty_no_bad_pop", bad_pop0, 0);

        // Reset during data bit 3 of 0x81.
        b81 = 8'h81;
        rd0 = rdc_of(0);
        push(0, b81);
        n = 0;
        while (tx_of(0) !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_frame_start", tx_of(0), 1'b0);
        repeat (4 + 3 * CPB + 1) @(negedge clk);
        check("rst_in_bit3", tx_of(0), b81[3]);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", tx_of(0), 1'b1);
        check("rst_mid_busy", busy_of(0), 1'b0);
        check("rst_mid_rd_en", rd_of(0), 1'b0);
        check("rst_mid_done", done_of(0), 1'b0);
        rst = 1'b0;
        idle_watch("rst_no_refetch", 0, 30);
        check("rst_rd_pulses", rdc_of(0) - rd0, 1);
        push(0, 8'h42);
        run_frame(0, 8'h42, -1, -1);

        // Random bytes, back-to-back, on both configurations.
        for (int s = 0; s < 2; s++) begin
            set_en(s, 1'b0);
            @(negedge clk);
            rd0 = rdc_of(s);
            for (int i = 0; i < 4; i++) begin
                r = 8'($urandom_range(0, 255));
                expq.push_back(r);
                push(s, r);
            end
            set_en(s, 1'b1);
            for (int i = 0; i < 4; i++) run_frame(s, expq.pop_front(), 2, -1);
            check("rand_rd_pulses", rdc_of(s) - rd0, 4);
            check("rand_fifo_empty", occ_of(s), 0);
        end

        bad = bad_pop0 + bad_pop1;
        check("no_pop_when_empty", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
